chev_seq_ctrl: RTL and testbench
================================

CHEV_SEQ_CTRL -- requirements
Module: chev_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the burn-in and sample counters.
REQ-002 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new sequence; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminate the current sequence.
REQ-006 SHALL have port seed  input  32  initial map value x0, captured with start.
REQ-007 SHALL have port burn_in  input  CNT_W  number of iterates to discard, captured with start.
REQ-008 SHALL have port num_samples  input  CNT_W  number of iterates to emit, captured with start.
REQ-009 SHALL have port out_ready  input  1  sink accepts out_data.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid iterate.
REQ-011 SHALL have port out_data  output  32  current iterate, saturated.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 SHALL use an FSM with states IDLE, LOAD, BURN, RUN, DONE.
REQ-015 IDLE: start=1 SHALL capture seed, burn_in and num_samples and move to LOAD. start while busy SHALL be ignored.
REQ-016 LOAD SHALL drive map input xt=seed for exactly one cycle. Next state SHALL be BURN if burn_in>0, RUN if burn_in=0 and num_samples>0, DONE otherwise.
REQ-017 Map output xtn (33 b, registered, 1-cycle latency) SHALL be saturated to 32 b: xtn[32]=1 -> 32'hFFFF_FFFF, else xtn[31:0].
REQ-018 Outside LOAD and stall, map input SHALL be sat(xtn). The map SHALL advance one iterate per cycle.
REQ-019 A register prev SHALL capture the map input every cycle.
REQ-020 Stall is RUN && !out_ready. During stall, map input SHALL be prev, so xtn recomputes the same iterate and out_data is held stable.
REQ-021 BURN SHALL last exactly burn_in cycles, discarding x1..x_burn_in. It SHALL then go to RUN, or to DONE if num_samples=0.
REQ-022 In RUN, out_valid SHALL be 1 and out_data SHALL equal sat(xtn). A transfer occurs when out_valid && out_ready.
REQ-023 Emitted sequence SHALL be x_(burn_in+1) .. x_(burn_in+num_samples), in order, with no duplicates or gaps regardless of out_ready pattern.
REQ-024 Latency: first out_valid SHALL occur burn_in+2 cycles after the cycle in which start is sampled.
REQ-025 The transfer with sample count = num_samples-1 SHALL move the FSM to DONE.
REQ-026 DONE SHALL assert done for one cycle, then return to IDLE. out_valid SHALL be 0 in DONE.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge. done SHALL not pulse, and out_valid SHALL drop that edge.
REQ-028 abort takes precedence over a simultaneous final transfer. That transfer still counts at the sink, but done SHALL not pulse.
REQ-029 Counters SHALL be CNT_W bits and SHALL never wrap. Maximum values burn_in = num_samples = 2^CNT_W-1 SHALL work.
REQ-030 out_data SHALL be don't-care when out_valid=0.

Reset
REQ-031 On rst_n low: state=IDLE; out_valid=0, done=0, busy=0, out_data=0.
REQ-032 On rst_n low: counters, prev and captured registers SHALL be 0, and the map register SHALL be 0.
REQ-033 Reset mid-sequence SHALL discard the sequence, with no done pulse.

Structure
REQ-034 Shared package chev_pkg SHALL hold the state enum, the 32'hFFFF_FFFF saturation constant, and the data widths (32/33).
REQ-035 SHALL instantiate exactly one sub-module, chev3D_map (x_{n+1}=4x^3-3x datapath), with clk/rst_n shared. All other logic SHALL be local.

Verification
REQ-036 seed=32'h4000_0000, burn_in=0, num_samples=4, out_ready=1 -> out_valid at cycle 2 after start, 4 back-to-back transfers equal to bench-model x1..x4, done pulses once.
REQ-037 seed=32'h1234_5678, burn_in=10, num_samples=3, out_ready=1 -> first out_valid at cycle 12, emitted values = model x11..x13.
REQ-038 burn_in=2, num_samples=5, out_ready toggling 1,0,0,1,0,1... -> out_data stable while stalled, sink receives model x3..x7 exactly once each.
REQ-039 burn_in=0, num_samples=0 -> LOAD then DONE, no out_valid, done pulses once, busy high 2 cycles.
REQ-040 abort asserted on 2nd RUN cycle of num_samples=8 -> IDLE next cycle, out_valid=0, no done, new start accepted afterwards.
REQ-041 rst_n pulsed low during BURN, then start with seed=32'hC000_0000 -> all outputs 0 during reset, new sequence matches model from x1.

Source files
------------

// File: rtl/chev_pkg.sv
// Shared types and constants for the Chebyshev sequence controller.
// Data path: 32-bit iterates, 33-bit raw map result saturated back to 32 bits.
package chev_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MAP_W  = 33;

   localparam logic [DATA_W-1:0] SAT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_BURN,
      ST_RUN,
      ST_DONE
   } state_e;

   function automatic logic [DATA_W-1:0] sat(input logic [MAP_W-1:0] v);
      return v[MAP_W-1] ? SAT_MAX : v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/chev3D_map.sv
// One step of the cubic Chebyshev map x' = 4x^3 - 3x, registered (1-cycle latency).
// The polynomial is evaluated on unsigned integers modulo 2^33.
module chev3D_map
   import chev_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] xt,
   output logic [MAP_W-1:0]  xtn
);

   logic [MAP_W-1:0] x_ext;
   logic [MAP_W-1:0] x_sq;
   logic [MAP_W-1:0] x_cu;
   logic [MAP_W-1:0] xtn_d;
   logic [MAP_W-1:0] xtn_q;

   always_comb begin
      x_ext = {1'b0, xt};
      x_sq  = x_ext * x_ext;
      x_cu  = x_sq * x_ext;
      xtn_d = (x_cu << 2) - (x_ext + (x_ext << 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xtn_q <= '0;
      end else begin
         xtn_q <= xtn_d;
      end
   end

   assign xtn = xtn_q;

endmodule

// File: rtl/chev_seq_ctrl.sv
// Sequence controller: seeds the Chebyshev map, discards burn_in iterates,
// then streams num_samples iterates over a valid/ready interface.
module chev_seq_ctrl
   import chev_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       seed,
   input  logic [CNT_W-1:0]  burn_in,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       seed_q, seed_d;
   logic [CNT_W-1:0]  burn_q, burn_d;
   logic [CNT_W-1:0]  nsamp_q, nsamp_d;
   logic [31:0]       prev_q, prev_d;

   logic [MAP_W-1:0]  xtn;
   logic [31:0]       xtn_sat;
   logic [31:0]       map_in;
   logic              stall;

   chev3D_map u_map (
      .clk   (clk),
      .rst_n (rst_n),
      .xt    (map_in),
      .xtn   (xtn)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         seed_q  <= '0;
         burn_q  <= '0;
         nsamp_q <= '0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         burn_q  <= burn_d;
         nsamp_q <= nsamp_d;
         prev_q  <= prev_d;
      end
   end

   // Counter only ever reaches limit-1, so maximum limits never wrap it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      burn_d  = burn_q;
      nsamp_d = nsamp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               seed_d  = seed;
               burn_d  = burn_in;
               nsamp_d = num_samples;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d = '0;
            if (burn_q != '0)       state_d = ST_BURN;
            else if (nsamp_q != '0) state_d = ST_RUN;
            else                    state_d = ST_DONE;
         end
         ST_BURN: begin
            if (cnt_q == burn_q - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = (nsamp_q != '0) ? ST_RUN : ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (out_ready) begin
               if (cnt_q == nsamp_q - CNT_W'(1)) state_d = ST_DONE;
               else                              cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
   end

   // Replaying the previous map input on a stall regenerates the same iterate.
   always_comb begin
      xtn_sat   = sat(xtn);
      stall     = (state_q == ST_RUN) && !out_ready;
      out_valid = (state_q == ST_RUN);
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      out_data  = out_valid ? xtn_sat : '0;
      if (state_q == ST_LOAD) map_in = seed_q;
      else if (stall)         map_in = prev_q;
      else                    map_in = xtn_sat;
      prev_d    = map_in;
   end

endmodule

// File: tb/tb_chev_seq_ctrl.sv
// Randomized scoreboard bench for chev_seq_ctrl against a full-precision
// arithmetic model of the saturated 4x^3-3x iteration.
module tb_chev_seq_ctrl;

   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [31:0]   seed;
   logic [CW-1:0] burn_in;
   logic [CW-1:0] num_samples;
   logic          out_ready;
   logic          out_valid;
   logic [31:0]   out_data;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   int xfer_cnt = 0;
   int ready_mode = 0;
   int pat_idx    = 0;
   logic [31:0] exp_q[$];

   chev_seq_ctrl #(.CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .seed        (seed),
      .burn_in     (burn_in),
      .num_samples (num_samples),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] x);
      logic [127:0] w;
      logic [127:0] v;
      w = {96'd0, x};
      v = 4 * w * w * w - 3 * w;
      return v[32] ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   // ready pattern for the stall scenario: 1,0,0,1,0,1 repeating
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (pat_idx % 6 == 0) || (pat_idx % 6 == 3) || (pat_idx % 6 == 5);
         default: out_ready = 1'b1;
      endcase
      pat_idx++;
   end

   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (out_valid && prev_stall) check("stall_hold", out_data, prev_data);
         if (done) begin
            done_cnt++;
            check("done_no_valid", out_valid, 1'b0);
         end
         if (busy) busy_cnt++;
         if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("unexpected_xfer", 1'b1, 1'b0);
            else check("out_data", out_data, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic issue_start(input logic [31:0] s, input int b, input int n);
      seed        = s;
      burn_in     = CW'(b);
      num_samples = CW'(n);
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic push_expected(input logic [31:0] s, input int b, input int n);
      logic [31:0] x;
      x = s;
      for (int i = 1; i <= b + n; i++) begin
         x = model_next(x);
         if (i > b) exp_q.push_back(x);
      end
   endtask

   // Full sequence: latency, values, done pulse and busy duration.
   task automatic run_seq(input logic [31:0] s, input int b, input int n, input int mode);
      int d0, b0, x0, lat, k, limit;
      limit = b + 6 * n + 40;
      ready_mode = mode;
      push_expected(s, b, n);
      d0 = done_cnt; b0 = busy_cnt; x0 = xfer_cnt;
      issue_start(s, b, n);
      lat = 1;
      @(negedge clk);
      while (!out_valid && busy && lat < limit) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      if (n > 0) check("first_valid_latency", lat, b + 2);
      k = 0;
      while (busy && k < limit) begin
         @(negedge clk); k++;
      end
      check("seq_terminated", busy, 1'b0);
      check("all_samples_received", exp_q.size(), 0);
      check("xfer_count", xfer_cnt - x0, n);
      check("done_once", done_cnt - d0, 1);
      if (mode == 0) check("busy_cycles", busy_cnt - b0, b + n + 2);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_out_data"}, out_data, 32'h0);
   endtask

   initial begin
      int d0, x0, k;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0;
      burn_in = '0; num_samples = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_seq(32'h4000_0000, 0, 4, 0);
      run_seq(32'h1234_5678, 10, 3, 0);
      run_seq(32'h0000_0007, 2, 5, 2);
      run_seq(32'h0BAD_F00D, 0, 0, 0);
      run_seq($urandom, 15, 15, 1);

      // abort on the second RUN cycle of an 8-sample sequence
      ready_mode = 0;
      push_expected(32'h2468_ACE1, 0, 8);
      d0 = done_cnt; x0 = xfer_cnt;
      issue_start(32'h2468_ACE1, 0, 8);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk); k++;
      end
      check("abort_reached_run", out_valid, 1'b1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_valid_drop", out_valid, 1'b0);
      check("abort_idle", busy, 1'b0);
      check("abort_xfers", xfer_cnt - x0, 2);
      @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      exp_q.delete();
      @(posedge clk); #1;
      run_seq(32'h0000_1003, 1, 3, 0);

      // reset during burn-in
      d0 = done_cnt;
      issue_start(32'h5555_1234, 12, 3);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #2 check_outputs_zero("midreset");
      @(posedge clk);
      #1 check_outputs_zero("midreset_hold");
      check("midreset_no_done", done_cnt - d0, 0);
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_seq(32'hC000_0000, 0, 4, 0);

      for (int t = 0; t < 6; t++)
         run_seq($urandom, int'($urandom_range(0, 5)), int'($urandom_range(1, 7)), int'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
